// File: rtl/xge_pkt_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : xge_pkt_rx_checker
// Function : Drains the 10G MAC RX packet interface and validates tester
//            payload frames (magic, sequence, length, incrementing words),
//            keeping saturating statistics. Optional debug capture of the
//            first mismatching word: XGE_PKT_CHK_DBG_CAPTURE_EN.
// Revision : 1.0 - initial release
// ============================================================================
module xge_pkt_rx_checker #(
    parameter int          CNT_W       = 32,
    parameter logic [15:0] MAGIC       = 16'h5A5A,
    parameter int          MIN_LEN     = 64,
    parameter int          MAX_LEN     = 1518,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic             clk_156,
    input  logic             reset_156,
    input  logic             chk_en,
    input  logic             clear_stats,
    input  logic             pkt_rx_avail,
    output logic             pkt_rx_ren,
    input  logic [63:0]      pkt_rx_data,
    input  logic             pkt_rx_sop,
    input  logic             pkt_rx_eop,
    input  logic             pkt_rx_val,
    input  logic             pkt_rx_err,
    input  logic [2:0]       pkt_rx_mod,
    output logic             chk_busy,
    output logic             chk_locked,
    output logic             pkt_done,
    output logic [CNT_W-1:0] pkt_good_cnt,
    output logic [CNT_W-1:0] pkt_bad_cnt,
    output logic [CNT_W-1:0] seq_err_cnt,
    output logic [CNT_W-1:0] len_err_cnt,
    output logic [CNT_W-1:0] data_err_cnt,
    output logic [CNT_W-1:0] mac_err_cnt,
    output logic [CNT_W-1:0] timeout_cnt,
    output logic [47:0]      byte_cnt,
    output logic [63:0]      dbg_exp,
    output logic [63:0]      dbg_act
);

    localparam int                c_to_w    = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYC - 1);
    localparam logic [31:0]       c_min_len = 32'(MIN_LEN);
    localparam logic [31:0]       c_max_len = 32'(MAX_LEN);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t r_state, w_state_nxt;

    logic              r_ren;
    logic              r_in_frame;
    logic [31:0]       r_seq;
    logic [15:0]       r_len;
    logic [31:0]       r_word_idx;
    logic [31:0]       r_bytes;
    logic [c_to_w-1:0] r_idle_cnt;
    logic              r_seq_err, r_len_err, r_data_err, r_mac_err;
    logic              r_locked;
    logic [31:0]       r_exp_seq;

    logic [CNT_W-1:0]  r_good, r_bad, r_seq_cnt, r_len_cnt, r_data_cnt, r_mac_cnt, r_to_cnt;
    logic [47:0]       r_byte_cnt;

    logic [3:0]        w_nbytes;
    logic [3:0]        w_word_bytes;
    logic [63:0]       w_mask;
    logic [63:0]       w_exp_word;
    logic              w_word_mism;
    logic [15:0]       w_len_eff;
    logic [31:0]       w_len32;
    logic [31:0]       w_total;
    logic              w_len_bad;
    logic              w_seq_bad;
    logic              w_rd_val, w_stray, w_resop, w_timeout;
    logic              w_commit;
    logic              w_f_seq, w_f_len, w_f_data, w_f_mac, w_f_to, w_f_bad;
    logic [48:0]       w_byte_sum;

    // Byte 0 sits in [63:56]; on the eop word only the upper mod bytes are real.
    always_comb begin
        w_nbytes = (pkt_rx_mod == 3'd0) ? 4'd8 : {1'b0, pkt_rx_mod};
        w_mask   = '1;
        if (pkt_rx_eop) begin
            for (int b = 0; b < 8; b++) begin
                if (b >= int'(w_nbytes)) begin
                    w_mask[63-8*b -: 8] = 8'h00;
                end
            end
        end
    end

    assign w_word_bytes = pkt_rx_eop ? w_nbytes : 4'd8;
    assign w_exp_word   = pkt_rx_sop ? {pkt_rx_data[63:16], MAGIC} : {r_seq, r_word_idx};
    assign w_word_mism  = ((pkt_rx_data ^ w_exp_word) & w_mask) != 64'd0;
    assign w_len_eff    = pkt_rx_sop ? pkt_rx_data[31:16] : r_len;
    assign w_len32      = {16'd0, w_len_eff};
    assign w_total      = (pkt_rx_sop ? 32'd0 : r_bytes) + {28'd0, w_word_bytes};
    assign w_len_bad    = pkt_rx_eop && ((w_len32 < c_min_len) || (w_len32 > c_max_len) ||
                                         (w_len32 != w_total));
    assign w_seq_bad    = pkt_rx_sop && r_locked && (pkt_rx_data[63:32] != r_exp_seq);

    assign w_rd_val  = (r_state == ST_READ) && pkt_rx_val;
    assign w_stray   = w_rd_val && !pkt_rx_sop && !r_in_frame;
    assign w_resop   = w_rd_val && pkt_rx_sop && r_in_frame;
    assign w_timeout = (r_state == ST_READ) && !pkt_rx_val && (r_idle_cnt == c_to_last);

    // Frames are committed to the statistics in DONE, or immediately when
    // an open frame is cut short by a new sop or by the read timeout.
    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_f_seq     = 1'b0;
        w_f_len     = 1'b0;
        w_f_data    = 1'b0;
        w_f_mac     = 1'b0;
        w_f_to      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (pkt_rx_avail && chk_en && !clear_stats) begin
                    w_state_nxt = ST_READ;
                end
            end
            ST_READ: begin
                if (w_timeout) begin
                    w_state_nxt = ST_IDLE;
                    w_commit    = 1'b1;
                    w_f_to      = 1'b1;
                end else if (pkt_rx_val && (pkt_rx_eop || w_stray)) begin
                    w_state_nxt = ST_DONE;
                end
                if (w_resop) begin
                    w_commit = 1'b1;
                    w_f_seq  = r_seq_err;
                    w_f_len  = r_len_err;
                    w_f_data = 1'b1;
                    w_f_mac  = r_mac_err;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
                w_commit    = 1'b1;
                w_f_seq     = r_seq_err;
                w_f_len     = r_len_err;
                w_f_data    = r_data_err;
                w_f_mac     = r_mac_err;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_f_bad = w_f_seq | w_f_len | w_f_data | w_f_mac | w_f_to;

    always_ff @(posedge clk_156) begin
        if (reset_156) begin
            r_state <= ST_IDLE;
            r_ren   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ren   <= (w_state_nxt == ST_READ);
        end
    end

    always_ff @(posedge clk_156) begin
        if (reset_156 || (r_state != ST_READ)) begin
            r_in_frame <= 1'b0;
            r_seq      <= '0;
            r_len      <= '0;
            r_word_idx <= '0;
            r_bytes    <= '0;
            r_idle_cnt <= '0;
            r_seq_err  <= 1'b0;
            r_len_err  <= 1'b0;
            r_data_err <= 1'b0;
            r_mac_err  <= 1'b0;
        end else begin
            r_idle_cnt <= pkt_rx_val ? '0 : r_idle_cnt + 1'b1;
            if (w_stray) begin
                r_data_err <= 1'b1;
                r_mac_err  <= pkt_rx_err;
            end else if (pkt_rx_val && pkt_rx_sop) begin
                r_in_frame <= 1'b1;
                r_seq      <= pkt_rx_data[63:32];
                r_len      <= pkt_rx_data[31:16];
                r_word_idx <= 32'd1;
                r_bytes    <= w_total;
                r_seq_err  <= w_seq_bad;
                r_len_err  <= w_len_bad;
                r_data_err <= w_word_mism;
                r_mac_err  <= pkt_rx_err;
            end else if (pkt_rx_val) begin
                r_word_idx <= r_word_idx + 32'd1;
                r_bytes    <= w_total;
                r_len_err  <= r_len_err  | w_len_bad;
                r_data_err <= r_data_err | w_word_mism;
                r_mac_err  <= r_mac_err  | pkt_rx_err;
            end
        end
    end

    // The reference always resyncs to the received sequence number.
    always_ff @(posedge clk_156) begin
        if (reset_156 || clear_stats) begin
            r_locked  <= 1'b0;
            r_exp_seq <= '0;
        end else if (w_rd_val && pkt_rx_sop) begin
            r_locked  <= 1'b1;
            r_exp_seq <= pkt_rx_data[63:32] + 32'd1;
        end
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    assign w_byte_sum = {1'b0, r_byte_cnt} + {33'd0, r_len};

    always_ff @(posedge clk_156) begin
        if (reset_156 || clear_stats) begin
            r_good     <= '0;
            r_bad      <= '0;
            r_seq_cnt  <= '0;
            r_len_cnt  <= '0;
            r_data_cnt <= '0;
            r_mac_cnt  <= '0;
            r_to_cnt   <= '0;
            r_byte_cnt <= '0;
        end else if (w_commit) begin
            r_good     <= sat_inc(r_good, !w_f_bad);
            r_bad      <= sat_inc(r_bad, w_f_bad);
            r_seq_cnt  <= sat_inc(r_seq_cnt, w_f_seq);
            r_len_cnt  <= sat_inc(r_len_cnt, w_f_len);
            r_data_cnt <= sat_inc(r_data_cnt, w_f_data);
            r_mac_cnt  <= sat_inc(r_mac_cnt, w_f_mac);
            r_to_cnt   <= sat_inc(r_to_cnt, w_f_to);
            if (!w_f_bad) begin
                r_byte_cnt <= w_byte_sum[48] ? '1 : w_byte_sum[47:0];
            end
        end
    end

`ifdef XGE_PKT_CHK_DBG_CAPTURE_EN
    logic        r_cap_vld;
    logic [63:0] r_dbg_exp, r_dbg_act;

    always_ff @(posedge clk_156) begin
        if (reset_156 || clear_stats) begin
            r_cap_vld <= 1'b0;
            r_dbg_exp <= '0;
            r_dbg_act <= '0;
        end else if (w_rd_val && !w_stray && w_word_mism && !r_cap_vld) begin
            r_cap_vld <= 1'b1;
            r_dbg_exp <= w_exp_word & w_mask;
            r_dbg_act <= pkt_rx_data & w_mask;
        end
    end

    assign dbg_exp = r_dbg_exp;
    assign dbg_act = r_dbg_act;
`else
    assign dbg_exp = 64'd0;
    assign dbg_act = 64'd0;
`endif

    assign pkt_rx_ren   = r_ren;
    assign chk_busy     = (r_state != ST_IDLE);
    assign chk_locked   = r_locked;
    assign pkt_done     = w_commit;
    assign pkt_good_cnt = r_good;
    assign pkt_bad_cnt  = r_bad;
    assign seq_err_cnt  = r_seq_cnt;
    assign len_err_cnt  = r_len_cnt;
    assign data_err_cnt = r_data_cnt;
    assign mac_err_cnt  = r_mac_cnt;
    assign timeout_cnt  = r_to_cnt;
    assign byte_cnt     = r_byte_cnt;

endmodule
`default_nettype wire

// File: tb/tb_xge_pkt_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_xge_pkt_rx_checker
// Function : Directed self-checking bench for xge_pkt_rx_checker.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_xge_pkt_rx_checker;

    logic        clk_156 = 1'b0;
    logic        reset_156;
    logic        chk_en;
    logic        clear_stats;
    logic        pkt_rx_avail;
    logic        pkt_rx_ren;
    logic [63:0] pkt_rx_data;
    logic        pkt_rx_sop, pkt_rx_eop, pkt_rx_val, pkt_rx_err;
    logic [2:0]  pkt_rx_mod;
    logic        chk_busy, chk_locked, pkt_done;
    logic [31:0] pkt_good_cnt, pkt_bad_cnt, seq_err_cnt, len_err_cnt;
    logic [31:0] data_err_cnt, mac_err_cnt, timeout_cnt;
    logic [47:0] byte_cnt;
    logic [63:0] dbg_exp, dbg_act;

    int n_checks = 0;
    int n_errors = 0;

    xge_pkt_rx_checker dut (
        .clk_156      (clk_156),
        .reset_156    (reset_156),
        .chk_en       (chk_en),
        .clear_stats  (clear_stats),
        .pkt_rx_avail (pkt_rx_avail),
        .pkt_rx_ren   (pkt_rx_ren),
        .pkt_rx_data  (pkt_rx_data),
        .pkt_rx_sop   (pkt_rx_sop),
        .pkt_rx_eop   (pkt_rx_eop),
        .pkt_rx_val   (pkt_rx_val),
        .pkt_rx_err   (pkt_rx_err),
        .pkt_rx_mod   (pkt_rx_mod),
        .chk_busy     (chk_busy),
        .chk_locked   (chk_locked),
        .pkt_done     (pkt_done),
        .pkt_good_cnt (pkt_good_cnt),
        .pkt_bad_cnt  (pkt_bad_cnt),
        .seq_err_cnt  (seq_err_cnt),
        .len_err_cnt  (len_err_cnt),
        .data_err_cnt (data_err_cnt),
        .mac_err_cnt  (mac_err_cnt),
        .timeout_cnt  (timeout_cnt),
        .byte_cnt     (byte_cnt),
        .dbg_exp      (dbg_exp),
        .dbg_act      (dbg_act)
    );

    always #3.2 clk_156 = ~clk_156;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk_156);
        #1;
    endtask

    task automatic settle();
        repeat (3) next_cyc();
    endtask

    task automatic pulse_clear();
        clear_stats = 1'b1;
        next_cyc();
        clear_stats = 1'b0;
    endtask

    task automatic bus_idle();
        pkt_rx_val  = 1'b0;
        pkt_rx_sop  = 1'b0;
        pkt_rx_eop  = 1'b0;
        pkt_rx_err  = 1'b0;
        pkt_rx_mod  = 3'd0;
        pkt_rx_data = 64'd0;
    endtask

    // Returns in the first READ cycle, after the edge that raised ren.
    task automatic start_read();
        bit seen;
        seen = 1'b0;
        pkt_rx_avail = 1'b1;
        for (int i = 0; i < 20; i++) begin
            next_cyc();
            if (pkt_rx_ren) begin
                seen = 1'b1;
                break;
            end
        end
        pkt_rx_avail = 1'b0;
        if (!seen) check("ren_wait", 64'd0, 64'd1);
    endtask

    task automatic drive_word(input logic [63:0] d, input bit sop, input bit eop,
                              input int mod, input bit err);
        pkt_rx_data = d;
        pkt_rx_sop  = sop;
        pkt_rx_eop  = eop;
        pkt_rx_mod  = 3'(mod);
        pkt_rx_err  = err;
        pkt_rx_val  = 1'b1;
        next_cyc();
    endtask

    function automatic logic [63:0] mk_word(input logic [31:0] seq, input logic [15:0] len,
                                            input int k);
        if (k == 0) return {seq, len, 16'h5A5A};
        return {seq, 32'(k)};
    endfunction

    // Invalid eop bytes are filled with junk so masking is exercised.
    task automatic send_frame(input logic [31:0] seq, input logic [15:0] len, input int nwords,
                              input int mod, input int bad_idx, input bit err_eop,
                              input bit drop_en);
        logic [63:0] d;
        start_read();
        if (drop_en) chk_en = 1'b0;
        for (int k = 0; k < nwords; k++) begin
            d = mk_word(seq, len, k);
            if (k == bad_idx) d = 64'd0;
            if ((k == nwords - 1) && (mod != 0)) d = d ^ ((64'd1 << (8 * (8 - mod))) - 64'd1);
            drive_word(d, k == 0, k == nwords - 1, mod, err_eop && (k == nwords - 1));
        end
        bus_idle();
        chk_en = 1'b1;
    endtask

    initial begin
        int n;
        reset_156    = 1'b1;
        chk_en       = 1'b1;
        clear_stats  = 1'b0;
        pkt_rx_avail = 1'b0;
        bus_idle();
        repeat (4) next_cyc();
        reset_156 = 1'b0;
        next_cyc();

        check("rst_good",   pkt_good_cnt, 0);
        check("rst_bad",    pkt_bad_cnt, 0);
        check("rst_bytes",  byte_cnt, 0);
        check("rst_locked", chk_locked, 0);
        check("rst_ren",    pkt_rx_ren, 0);
        check("rst_busy",   chk_busy, 0);

        // Three good 64-byte frames; chk_en dropped mid-frame on the last.
        send_frame(32'd0, 16'd64, 8, 0, -1, 1'b0, 1'b0);
        check("done_pulse", pkt_done, 1);
        check("done_busy",  chk_busy, 1);
        send_frame(32'd1, 16'd64, 8, 0, -1, 1'b0, 1'b0);
        send_frame(32'd2, 16'd64, 8, 0, -1, 1'b0, 1'b1);
        settle();
        check("t1_good",   pkt_good_cnt, 3);
        check("t1_bytes",  byte_cnt, 192);
        check("t1_locked", chk_locked, 1);
        check("t1_bad",    pkt_bad_cnt, 0);
        check("t1_seq",    seq_err_cnt, 0);
        check("t1_len",    len_err_cnt, 0);
        check("t1_data",   data_err_cnt, 0);
        check("t1_done_lo", pkt_done, 0);

        pulse_clear();
        check("clr_good",   pkt_good_cnt, 0);
        check("clr_locked", chk_locked, 0);

        // Partial eop word, then a sequence gap, then back in sequence.
        send_frame(32'd5, 16'd67, 9, 3, -1, 1'b0, 1'b0);
        send_frame(32'd7, 16'd64, 8, 0, -1, 1'b0, 1'b0);
        settle();
        check("t2_good",  pkt_good_cnt, 1);
        check("t2_bad",   pkt_bad_cnt, 1);
        check("t2_seq",   seq_err_cnt, 1);
        check("t2_bytes", byte_cnt, 67);
        check("t2_len",   len_err_cnt, 0);
        send_frame(32'd8, 16'd64, 8, 0, -1, 1'b0, 1'b0);
        settle();
        check("t2_seq8",   seq_err_cnt, 1);
        check("t2_good8",  pkt_good_cnt, 2);
        check("t2_bytes8", byte_cnt, 131);

        // Corrupted data word 3.
        pulse_clear();
        send_frame(32'd20, 16'd128, 16, 0, 3, 1'b0, 1'b0);
        settle();
        check("t3_data", data_err_cnt, 1);
        check("t3_bad",  pkt_bad_cnt, 1);
        check("t3_good", pkt_good_cnt, 0);
`ifdef XGE_PKT_CHK_DBG_CAPTURE_EN
        check("t3_dbg_exp", dbg_exp, {32'd20, 32'd3});
        check("t3_dbg_act", dbg_act, 64'd0);
        send_frame(32'd21, 16'd64, 8, 0, 5, 1'b0, 1'b0);
        settle();
        check("t3_dbg_keep", dbg_exp, {32'd20, 32'd3});
`else
        check("t3_dbg_exp", dbg_exp, 64'd0);
        check("t3_dbg_act", dbg_act, 64'd0);
`endif

        // Length mismatch plus MAC error: one bad frame.
        pulse_clear();
        send_frame(32'd30, 16'd100, 16, 0, -1, 1'b1, 1'b0);
        settle();
        check("t4_len",  len_err_cnt, 1);
        check("t4_mac",  mac_err_cnt, 1);
        check("t4_bad",  pkt_bad_cnt, 1);
        check("t4_data", data_err_cnt, 0);

        // Single-word frame.
        pulse_clear();
        send_frame(32'd40, 16'd64, 1, 0, -1, 1'b0, 1'b0);
        settle();
        check("t5_len",  len_err_cnt, 1);
        check("t5_bad",  pkt_bad_cnt, 1);
        check("t5_good", pkt_good_cnt, 0);

        // val without sop as the first word.
        pulse_clear();
        start_read();
        drive_word(64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0, 0, 1'b0);
        bus_idle();
        settle();
        check("t6_bad",  pkt_bad_cnt, 1);
        check("t6_data", data_err_cnt, 1);
        check("t6_busy", chk_busy, 0);

        // Read timeout.
        pulse_clear();
        start_read();
        n = 0;
        for (int i = 0; i < 1100; i++) begin
            next_cyc();
            n++;
            if (!pkt_rx_ren) break;
        end
        check("t7_cycles", n, 1024);
        next_cyc();
        check("t7_to",   timeout_cnt, 1);
        check("t7_bad",  pkt_bad_cnt, 1);
        check("t7_busy", chk_busy, 0);
        check("t7_ren",  pkt_rx_ren, 0);

        // chk_en low blocks new reads.
        chk_en = 1'b0;
        pkt_rx_avail = 1'b1;
        repeat (5) next_cyc();
        check("t8_ren",  pkt_rx_ren, 0);
        check("t8_busy", chk_busy, 0);
        pkt_rx_avail = 1'b0;
        chk_en = 1'b1;

        // Second sop in an open frame, then clear_stats in DONE.
        pulse_clear();
        start_read();
        drive_word(mk_word(32'd50, 16'd64, 0), 1'b1, 1'b0, 0, 1'b0);
        drive_word(mk_word(32'd50, 16'd64, 1), 1'b0, 1'b0, 0, 1'b0);
        drive_word(mk_word(32'd50, 16'd64, 2), 1'b0, 1'b0, 0, 1'b0);
        drive_word(mk_word(32'd51, 16'd64, 0), 1'b1, 1'b0, 0, 1'b0);
        check("t9_abort_bad",  pkt_bad_cnt, 1);
        check("t9_abort_data", data_err_cnt, 1);
        for (int k = 1; k < 8; k++) begin
            drive_word(mk_word(32'd51, 16'd64, k), 1'b0, k == 7, 0, 1'b0);
        end
        bus_idle();
        check("t9_done", pkt_done, 1);
        pulse_clear();
        check("t9_good",   pkt_good_cnt, 0);
        check("t9_bad",    pkt_bad_cnt, 0);
        check("t9_data",   data_err_cnt, 0);
        check("t9_seq",    seq_err_cnt, 0);
        check("t9_bytes",  byte_cnt, 0);
        check("t9_locked", chk_locked, 0);

        // Reset mid-frame.
        start_read();
        drive_word(mk_word(32'd60, 16'd64, 0), 1'b1, 1'b0, 0, 1'b0);
        reset_156 = 1'b1;
        next_cyc();
        check("t10_ren",  pkt_rx_ren, 0);
        check("t10_busy", chk_busy, 0);
        reset_156 = 1'b0;
        bus_idle();
        settle();
        check("t10_good", pkt_good_cnt, 0);
        check("t10_bad",  pkt_bad_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
